ahb_addr_decoder: RTL
=====================

AHB_ADDR_DECODER -- requirements
Module: ahb_addr_decoder

Interface
REQ-001 Parameters SHALL be:
- NUM_SLAVES, default 3, number of mapped slaves.
- ADDR_W, default 16, haddr width.
- DATA_W, default 32, read data width.
- SEL_BITS, default 2, upper haddr bits used as the region index; 2^SEL_BITS >= NUM_SLAVES.

REQ-002 Ports SHALL be:
- hclk  in  1  single clock, all state on rising edge.
- hresetn  in  1  asynchronous, active-low reset.
- haddr  in  ADDR_W  address-phase address.
- htrans  in  2  transfer type; bit 1 set = NONSEQ/SEQ.
- hsel  out  NUM_SLAVES  one-hot slave select.
- hrdata_s  in  NUM_SLAVES*DATA_W  slave read data; slave k at [k*DATA_W +: DATA_W].
- hreadyout_s  in  NUM_SLAVES  per-slave ready.
- hresp_s  in  NUM_SLAVES  per-slave response; 1 = ERROR.
- hrdata  out  DATA_W  muxed read data to master.
- hready  out  1  muxed ready to master and slaves.
- hresp  out  1  muxed response to master.
- sel_slave  out  SEL_BITS  registered data-phase region index.

Function
REQ-003 Region index idx = haddr[ADDR_W-1 -: SEL_BITS]. hsel[idx] SHALL be 1 when idx < NUM_SLAVES; otherwise hsel SHALL be all 0. hsel is combinational and not gated by htrans.
REQ-004 On each rising hclk with hready=1, sel_slave SHALL load idx, and internal dp_valid SHALL load htrans[1]. With hready=0, both SHALL hold.
REQ-005 Data-phase mux, when dp_valid=1 and sel_slave < NUM_SLAVES: hrdata, hready and hresp SHALL equal hrdata_s, hreadyout_s and hresp_s of slave sel_slave, combinationally, with zero added latency.
REQ-006 When dp_valid=0: hready=1, hresp=0, hrdata=0.
REQ-007 When dp_valid=1 and sel_slave >= NUM_SLAVES (unmapped), the response SHALL follow REQ-012 or REQ-013.
REQ-008 Default-slave FSM states SHALL be IDLE, ERR1 and ERR2.
- IDLE->ERR1 on a clock edge with hready=1, htrans[1]=1 and idx unmapped.
- ERR1->ERR2 unconditionally.
- ERR2->ERR1 if a new unmapped NONSEQ/SEQ is presented; otherwise ERR2->IDLE.
REQ-009 FSM outputs, which override REQ-005/006:
- ERR1: hready=0, hresp=1, hrdata=0.
- ERR2: hready=1, hresp=1, hrdata=0.
REQ-010 An IDLE/BUSY transfer to an unmapped address SHALL NOT leave IDLE and SHALL receive an OKAY zero-wait response.
REQ-011 A mapped transfer presented in ERR2 SHALL register normally (hready=1) and return the FSM to IDLE.

Configuration
REQ-012 With DECODER_DEFAULT_SLAVE_EN defined, the FSM of REQ-008/009 SHALL be compiled in, and unmapped NONSEQ/SEQ transfers SHALL receive the two-cycle ERROR response.
REQ-013 Without DECODER_DEFAULT_SLAVE_EN, the FSM SHALL be absent, and unmapped data phases SHALL return hready=1, hresp=0, hrdata=0 (silent OKAY, no bus hang).

Reset
REQ-014 While hresetn=0, regardless of hclk: sel_slave=0, dp_valid=0, FSM=IDLE; hence hready=1, hresp=0, hrdata=0.
REQ-015 Reset asserted mid-operation, including in ERR1/ERR2 or during a slave wait state, SHALL abort immediately to the REQ-014 values. The first transfer after deassertion is accepted on the first rising edge with hresetn=1.

Verification (defaults, macro defined unless noted)
REQ-016 haddr=0x4000, htrans=NONSEQ, slave1 hrdata_s=0xA5A5A5A5 -> hsel=3'b010 same cycle; next cycle sel_slave=1, hrdata=0xA5A5A5A5, hready=1, hresp=0.
REQ-017 haddr=0xC000, htrans=NONSEQ -> hsel=0; next cycle hready=0/hresp=1; following cycle hready=1/hresp=1; then IDLE with hready=1/hresp=0.
REQ-018 Macro undefined, haddr=0xC000 NONSEQ -> next cycle hready=1, hresp=0, hrdata=0.
REQ-019 Slave2 transfer (haddr=0x8000), hreadyout_s[2] low for 3 cycles while haddr changes to 0x0000 -> sel_slave stays 2 and hready=0 for 3 cycles; sel_slave becomes 0 on the edge after hready returns to 1.
REQ-020 hresetn pulsed low during ERR1 -> hready=1, hresp=0, sel_slave=0 immediately; a NONSEQ to 0x0000 after release completes OKAY.
REQ-021 haddr=0xC000, htrans=IDLE -> no ERR states; hready=1, hresp=0.

Source files
------------

// File: rtl/ahb_addr_decoder_if.sv
// AHB decoder bus bundle: address-phase request, per-slave return paths,
// and the muxed data-phase response back to the master.
interface ahb_addr_decoder_if #(
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_BITS   = 2
);
    logic [ADDR_W-1:0]            haddr;
    logic [1:0]                   htrans;
    logic [NUM_SLAVES-1:0]        hsel;
    logic [NUM_SLAVES*DATA_W-1:0] hrdata_s;
    logic [NUM_SLAVES-1:0]        hreadyout_s;
    logic [NUM_SLAVES-1:0]        hresp_s;
    logic [DATA_W-1:0]            hrdata;
    logic                         hready;
    logic                         hresp;
    logic [SEL_BITS-1:0]          sel_slave;

    // Fabric side: drives the request and the slave return paths.
    modport master (
        output haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
        input  hsel, hrdata, hready, hresp, sel_slave
    );

    // Decoder side.
    modport slave (
        input  haddr, htrans, hrdata_s, hreadyout_s, hresp_s,
        output hsel, hrdata, hready, hresp, sel_slave
    );
endinterface

// File: rtl/ahb_addr_decoder.sv
// AHB address decoder with data-phase response mux.
// The upper SEL_BITS of haddr pick a region; regions >= NUM_SLAVES are
// unmapped. Define DECODER_DEFAULT_SLAVE_EN to build in a default slave
// that answers unmapped NONSEQ/SEQ transfers with a two-cycle ERROR;
// without it, unmapped data phases get a zero-wait OKAY with zero data.
module ahb_addr_decoder #(
    parameter int unsigned NUM_SLAVES = 3,
    parameter int unsigned ADDR_W     = 16,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned SEL_BITS   = 2
) (
    input logic                hclk,
    input logic                hresetn,
    ahb_addr_decoder_if.slave  bus
);

    logic [SEL_BITS-1:0] idx;
    logic                idx_mapped;
    logic                dp_valid;
    logic                dp_mapped;
    logic [DATA_W-1:0]   mux_rdata;
    logic                mux_ready;
    logic                mux_resp;
    logic                unused_bits;

    assign idx         = bus.haddr[ADDR_W-1 -: SEL_BITS];
    assign unused_bits = ^{bus.haddr[ADDR_W-SEL_BITS-1:0], bus.htrans[0]};

    // Region decode and one-hot slave select (not gated by htrans).
    always_comb begin
        idx_mapped = (32'(idx) < NUM_SLAVES);
        dp_mapped  = (32'(bus.sel_slave) < NUM_SLAVES);
        bus.hsel   = '0;
        for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
            if (32'(idx) == k) begin
                bus.hsel[k] = 1'b1;
            end
        end
    end

    // Data-phase state: advances only when the bus is ready.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            bus.sel_slave <= '0;
            dp_valid      <= 1'b0;
        end else if (bus.hready) begin
            bus.sel_slave <= idx;
            dp_valid      <= bus.htrans[1];
        end
    end

    // Response mux from the data-phase slave; idle/unmapped gives OKAY zero.
    always_comb begin
        mux_rdata = '0;
        mux_ready = 1'b1;
        mux_resp  = 1'b0;
        if (dp_valid && dp_mapped) begin
            for (int unsigned k = 0; k < NUM_SLAVES; k++) begin
                if (32'(bus.sel_slave) == k) begin
                    mux_rdata = bus.hrdata_s[k*DATA_W +: DATA_W];
                    mux_ready = bus.hreadyout_s[k];
                    mux_resp  = bus.hresp_s[k];
                end
            end
        end
    end

`ifdef DECODER_DEFAULT_SLAVE_EN
    typedef enum logic [1:0] {
        IDLE,
        ERR1,
        ERR2
    } state_t;

    state_t state, state_next;

    // Default-slave state register.
    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Default-slave next state and response override of the mux.
    always_comb begin
        state_next = state;
        bus.hrdata = mux_rdata;
        bus.hready = mux_ready;
        bus.hresp  = mux_resp;
        case (state)
            IDLE: begin
                if (mux_ready && bus.htrans[1] && !idx_mapped) begin
                    state_next = ERR1;
                end
            end
            ERR1: begin
                bus.hrdata = '0;
                bus.hready = 1'b0;
                bus.hresp  = 1'b1;
                state_next = ERR2;
            end
            ERR2: begin
                bus.hrdata = '0;
                bus.hready = 1'b1;
                bus.hresp  = 1'b1;
                state_next = (bus.htrans[1] && !idx_mapped) ? ERR1 : IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end
`else
    // No default slave: unmapped phases already resolve to OKAY zero in the mux.
    always_comb begin
        bus.hrdata = mux_rdata;
        bus.hready = mux_ready;
        bus.hresp  = mux_resp;
    end
`endif

endmodule
